// File: rtl/capture_if.sv
// Capture controller control/status bundle.
// master drives the control pulses, slave is the controller.
interface capture_if #(
    parameter int LOG2 = 9
);
    logic            start;
    logic            abort;
    logic            smpl_en;
    logic            triggered;
    logic [LOG2-1:0] trig_pos;
    logic            dump_req;
    logic            dump_nxt;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic [LOG2-1:0] raddr;
    logic            armed;
    logic            capture_done;
    logic            rd_vld;
    logic            dump_last;

    modport master (
        output start, abort, smpl_en, triggered, trig_pos,
        output dump_req, dump_nxt,
        input  we, waddr, raddr, armed, capture_done,
        input  rd_vld, dump_last
    );

    modport slave (
        input  start, abort, smpl_en, triggered, trig_pos,
        input  dump_req, dump_nxt,
        output we, waddr, raddr, armed, capture_done,
        output rd_vld, dump_last
    );
endinterface

// File: rtl/capture_ctrl.sv
// Circular-buffer capture controller: pre-trigger fill, trigger,
// post-trigger fill, freeze, then ordered readout oldest-first.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input logic      clk,
    input logic      rst_n,
    capture_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE,
        S_DUMP
    } state_t;

    localparam logic [LOG2-1:0] LAST_A = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   ENT_N  = (LOG2+1)'(ENTRIES);

    state_t          state_q, state_d;
    logic [LOG2-1:0] tp_q, tp_d;
    logic [LOG2-1:0] waddr_q, waddr_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [LOG2:0]   pre_q, pre_d;
    logic [LOG2-1:0] post_q, post_d;
    logic [LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic            done_q, done_d;
    logic            s1_q, s1_d;
    logic            s1l_q, s1l_d;
    logic            s2_q, s2_d;
    logic            s2l_q, s2l_d;
    logic            vld_q, vld_d;
    logic            lst_q, lst_d;

    logic            we_c;
    logic            go;
    logic            iss;
    logic            iss_last;
    logic [LOG2-1:0] tp_in;
    logic [LOG2:0]   pre_tgt;

    function automatic logic [LOG2-1:0] inc_a(input logic [LOG2-1:0] a);
        return (a == LAST_A) ? '0 : a + LOG2'(1);
    endfunction

    // Out-of-range trigger positions clamp to the last buffer slot.
    assign tp_in   = ({1'b0, bus.trig_pos} >= ENT_N) ? LAST_A : bus.trig_pos;
    assign pre_tgt = ENT_N - {1'b0, tp_q};

    // Next-state, address/counter updates and read-issue pipeline.
    always_comb begin
        state_d  = state_q;
        tp_d     = tp_q;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        pre_d    = pre_q;
        post_d   = post_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = done_q;
        we_c     = 1'b0;
        go       = 1'b0;
        iss      = 1'b0;
        iss_last = 1'b0;
        s1_d     = 1'b0;
        s1l_d    = 1'b0;
        s2_d     = s1_q;
        s2l_d    = s1l_q;
        vld_d    = s2_q;
        lst_d    = s2l_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            s2_d    = 1'b0;
            s2l_d   = 1'b0;
            vld_d   = 1'b0;
            lst_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    go = bus.start;
                end
                S_FILL: begin
                    we_c = bus.smpl_en;
                    if (bus.smpl_en) begin
                        waddr_d = inc_a(waddr_q);
                        pre_d   = pre_q + (LOG2+1)'(1);
                        if (pre_d == pre_tgt) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    we_c = bus.smpl_en;
                    if (bus.smpl_en) begin
                        waddr_d = inc_a(waddr_q);
                    end
                    if (bus.triggered) begin
                        state_d = S_POST;
                        post_d  = '0;
                    end
                end
                S_POST: begin
                    if (post_q == tp_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        we_c = bus.smpl_en;
                        if (bus.smpl_en) begin
                            waddr_d = inc_a(waddr_q);
                            post_d  = post_q + LOG2'(1);
                            if (post_d == tp_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        go = 1'b1;
                    end else if (bus.dump_req) begin
                        state_d  = S_DUMP;
                        rd_cnt_d = '0;
                        raddr_d  = waddr_q;
                        iss      = 1'b1;
                    end
                end
                S_DUMP: begin
                    if (bus.dump_nxt) begin
                        raddr_d  = inc_a(raddr_q);
                        rd_cnt_d = rd_cnt_q + LOG2'(1);
                        iss      = 1'b1;
                        if (rd_cnt_d == LAST_A) begin
                            iss_last = 1'b1;
                            state_d  = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (go) begin
                state_d = S_FILL;
                tp_d    = tp_in;
                pre_d   = '0;
                post_d  = '0;
                waddr_d = '0;
                done_d  = 1'b0;
            end

            s1_d  = iss;
            s1l_d = iss_last;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tp_q     <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            pre_q    <= '0;
            post_q   <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
            s1_q     <= 1'b0;
            s1l_q    <= 1'b0;
            s2_q     <= 1'b0;
            s2l_q    <= 1'b0;
            vld_q    <= 1'b0;
            lst_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tp_q     <= tp_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            pre_q    <= pre_d;
            post_q   <= post_d;
            rd_cnt_q <= rd_cnt_d;
            done_q   <= done_d;
            s1_q     <= s1_d;
            s1l_q    <= s1l_d;
            s2_q     <= s2_d;
            s2l_q    <= s2l_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
        end
    end

    assign bus.we           = we_c;
    assign bus.waddr        = waddr_q;
    assign bus.raddr        = raddr_q;
    assign bus.armed        = (state_q == S_ARMED);
    assign bus.capture_done = done_q;
    assign bus.rd_vld       = vld_q;
    assign bus.dump_last    = lst_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized and directed bench for capture_ctrl against a
// count-based reference model of the capture/dump rules.
module tb_capture_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk;
    logic rst_n;

    capture_if #(.LOG2(LOG2)) cif ();

    capture_ctrl #(
        .ENTRIES(ENTRIES),
        .LOG2   (LOG2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int cyc;

    // model: 0 idle, 1 capturing, 2 capture complete
    int m_cap;
    bit m_trig;
    int m_trig_wr;
    int m_nwr;
    int m_tp;
    int m_raddr;
    bit m_dump;
    int m_niss;
    bit exp_vld[int];
    bit exp_last[int];

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)",
                      tag, obs, exp, cyc);
    endtask

    function automatic int post_n();
        return m_nwr - m_trig_wr;
    endfunction

    function automatic bit armed_e();
        return m_cap == 1 && !m_trig && m_nwr >= ENTRIES - m_tp;
    endfunction

    function automatic bit we_e();
        return m_cap == 1 && !cif.abort && cif.smpl_en &&
               !(m_trig && post_n() == m_tp);
    endfunction

    task automatic m_reset();
        m_cap = 0;
        m_trig = 0;
        m_trig_wr = 0;
        m_nwr = 0;
        m_tp = 0;
        m_raddr = 0;
        m_dump = 0;
        m_niss = 0;
        exp_vld.delete();
        exp_last.delete();
    endtask

    task automatic m_issue(input bit last);
        exp_vld[cyc + 3] = 1'b1;
        if (last) exp_last[cyc + 3] = 1'b1;
    endtask

    task automatic m_begin();
        m_cap = 1;
        m_trig = 0;
        m_nwr = 0;
        m_tp = (int'(cif.trig_pos) >= ENTRIES) ? ENTRIES - 1
                                                : int'(cif.trig_pos);
    endtask

    task automatic m_step();
        bit a;
        bit w;
        if (!rst_n) begin
            m_reset();
        end else if (cif.abort) begin
            m_cap = 0;
            m_trig = 0;
            m_dump = 0;
            for (int k = 1; k <= 3; k++) begin
                exp_vld.delete(cyc + k);
                exp_last.delete(cyc + k);
            end
        end else if (m_cap == 0) begin
            if (cif.start) m_begin();
        end else if (m_cap == 1) begin
            a = armed_e();
            w = we_e();
            if (w) m_nwr++;
            if (!m_trig) begin
                if (a && cif.triggered) begin
                    m_trig = 1;
                    m_trig_wr = m_nwr;
                end
            end else if (post_n() == m_tp) begin
                m_cap = 2;
            end
        end else if (m_dump) begin
            if (cif.dump_nxt) begin
                m_raddr = (m_raddr + 1) % ENTRIES;
                m_niss++;
                m_issue(m_niss == ENTRIES);
                if (m_niss == ENTRIES) m_dump = 0;
            end
        end else if (cif.start) begin
            m_begin();
        end else if (cif.dump_req) begin
            m_dump = 1;
            m_raddr = m_nwr % ENTRIES;
            m_niss = 1;
            m_issue(ENTRIES == 1);
        end
    endtask

    task automatic m_compare();
        chk("we", cif.we, we_e());
        chk("waddr", cif.waddr, m_nwr % ENTRIES);
        chk("raddr", cif.raddr, m_raddr);
        chk("armed", cif.armed, armed_e());
        chk("capture_done", cif.capture_done, m_cap == 2);
        chk("rd_vld", cif.rd_vld, exp_vld.exists(cyc));
        chk("dump_last", cif.dump_last, exp_last.exists(cyc));
    endtask

    task automatic tick();
        @(negedge clk);
        m_compare();
        @(posedge clk);
        m_step();
        cyc++;
        #1;
        cif.start = 1'b0;
        cif.abort = 1'b0;
        cif.dump_req = 1'b0;
        cif.dump_nxt = 1'b0;
    endtask

    task automatic do_start(input int tp);
        cif.trig_pos = LOG2'(tp);
        cif.start = 1'b1;
        tick();
    endtask

    function automatic logic [LOG2-1:0] pick_tp();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return LOG2'(1);
            2: return LOG2'($urandom_range(2, 60));
            3: return LOG2'(ENTRIES - 1);
            4: return LOG2'($urandom_range(ENTRIES, 511));
            default: return LOG2'($urandom_range(0, 511));
        endcase
    endfunction

    initial begin
        int nv;
        int nl;
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        rst_n = 1'b0;
        cif.start = 1'b0;
        cif.abort = 1'b0;
        cif.smpl_en = 1'b0;
        cif.triggered = 1'b0;
        cif.trig_pos = '0;
        cif.dump_req = 1'b0;
        cif.dump_nxt = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        tick();
        rst_n = 1'b1;
        tick();

        // nominal capture, trig_pos 100
        do_start(100);
        cif.smpl_en = 1'b1;
        repeat (283) tick();
        chk("r36_arm283", cif.armed, 0);
        tick();
        chk("r36_arm284", cif.armed, 1);
        repeat (15) tick();
        cif.triggered = 1'b1;
        tick();
        cif.triggered = 1'b0;
        for (int i = 0; i < 200 && !cif.capture_done; i++) tick();
        chk("r36_done", cif.capture_done, 1);
        chk("r36_wa", cif.waddr, 16);
        cif.smpl_en = 1'b0;

        // full dump, dump_nxt every third cycle
        cif.dump_req = 1'b1;
        tick();
        chk("r39_ra0", cif.raddr, 16);
        nv = 0;
        nl = 0;
        for (int i = 0; i < ENTRIES * 3 + 30; i++) begin
            cif.dump_nxt = (i % 3 == 2);
            tick();
            nv += int'(cif.rd_vld);
            nl += int'(cif.dump_last);
        end
        chk("r39_nvld", nv, ENTRIES);
        chk("r39_nlast", nl, 1);
        chk("r39_ra_end", cif.raddr, 15);
        chk("r39_done", cif.capture_done, 1);

        // zero post-trigger samples
        do_start(0);
        cif.smpl_en = 1'b1;
        for (int i = 0; i < 500 && !cif.armed; i++) tick();
        chk("tp0_arm", cif.armed, 1);
        cif.triggered = 1'b1;
        tick();
        cif.triggered = 1'b0;
        tick();
        chk("tp0_done", cif.capture_done, 1);
        chk("tp0_wa", cif.waddr, 1);

        // oversized trig_pos clamps to ENTRIES-1
        cif.smpl_en = 1'b0;
        do_start(500);
        cif.smpl_en = 1'b1;
        tick();
        chk("tp500_arm", cif.armed, 1);
        cif.abort = 1'b1;
        tick();
        chk("ab_arm", cif.armed, 0);

        // trigger held from start
        cif.triggered = 1'b1;
        do_start(300);
        for (int i = 0; i < 600 && !cif.capture_done; i++) tick();
        chk("hold_done", cif.capture_done, 1);
        chk("hold_wa", cif.waddr, 1);

        // abort during post-trigger fill
        do_start(200);
        for (int i = 0; i < 600 && !cif.armed; i++) tick();
        repeat (50) tick();
        chk("ap_inpost", cif.armed, 0);
        cif.abort = 1'b1;
        tick();
        chk("ap_done", cif.capture_done, 0);
        chk("ap_we", cif.we, 0);

        // abort during dump
        do_start(5);
        for (int i = 0; i < 600 && !cif.capture_done; i++) tick();
        chk("ad_cap", cif.capture_done, 1);
        cif.triggered = 1'b0;
        cif.smpl_en = 1'b0;
        cif.dump_req = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            cif.dump_nxt = 1'b1;
            tick();
        end
        cif.abort = 1'b1;
        cif.dump_nxt = 1'b1;
        tick();
        nv = 0;
        repeat (6) begin
            tick();
            nv += int'(cif.rd_vld);
        end
        chk("ad_vld", nv, 0);
        chk("ad_done", cif.capture_done, 0);

        // reset while armed with samples streaming
        cif.smpl_en = 1'b1;
        do_start(10);
        for (int i = 0; i < 600 && !cif.armed; i++) tick();
        chk("rs_pre", cif.armed, 1);
        rst_n = 1'b0;
        tick();
        chk("rs_arm", cif.armed, 0);
        chk("rs_wa", cif.waddr, 0);
        chk("rs_we", cif.we, 0);
        rst_n = 1'b1;
        do_start(10);
        tick();
        chk("rs_wa1", cif.waddr, 1);

        // randomized traffic
        for (int i = 0; i < 9000; i++) begin
            rst_n = ($urandom_range(0, 4999) != 0);
            cif.smpl_en = ($urandom_range(0, 3) != 0);
            cif.triggered = ($urandom_range(0, 5) == 0);
            cif.dump_nxt = $urandom_range(0, 1);
            cif.trig_pos = pick_tp();
            cif.abort = ($urandom_range(0, 1999) == 0);
            cif.dump_req = ($urandom_range(0, 99) == 0);
            if (m_cap == 0) begin
                cif.start = ($urandom_range(0, 15) == 0);
            end else if (m_cap == 2 && !m_dump) begin
                cif.start = ($urandom_range(0, 99) == 0);
                cif.dump_req = ($urandom_range(0, 7) == 0);
            end else begin
                cif.start = ($urandom_range(0, 199) == 0);
            end
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384: circular capture buffer depth in samples.
REQ-002 Parameter LOG2, default 9: address width; 2^LOG2 >= ENTRIES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begin a new capture.
REQ-006 abort  input  1  one-cycle pulse; cancel capture or dump.
REQ-007 smpl_en  input  1  one-cycle strobe; a new sample is present on the datapath this cycle.
REQ-008 triggered  input  1  trigger event from the trigger logic.
REQ-009 trig_pos  input  LOG2  number of samples stored after the trigger; sampled on accepted start.
REQ-010 dump_req  input  1  one-cycle pulse; begin readout of a completed capture.
REQ-011 dump_nxt  input  1  one-cycle pulse from consumer; fetch next sample during dump.
REQ-012 we  output  1  buffer write enable.
REQ-013 waddr  output  LOG2  buffer write address.
REQ-014 raddr  output  LOG2  buffer read address.
REQ-015 armed  output  1  pre-trigger fill complete; trigger now accepted.
REQ-016 capture_done  output  1  capture complete, buffer frozen.
REQ-017 rd_vld  output  1  buffer rdata valid this cycle.
REQ-018 dump_last  output  1  qualifies rd_vld for final sample of a dump.

Function
REQ-019 FSM states IDLE, FILL, ARMED, POST, DONE, DUMP; one state at a time.
REQ-020 start accepted only in IDLE or DONE -> FILL; latch trig_pos (values >= ENTRIES clamp to ENTRIES-1); clear pre_cnt, post_cnt, waddr to 0; capture_done := 0.
REQ-021 In FILL/ARMED/POST: we = smpl_en (combinational, same cycle); waddr increments by 1 after each write, wrapping ENTRIES-1 -> 0 (never reaches ENTRIES).
REQ-022 FILL: pre_cnt counts writes; -> ARMED on the write that makes pre_cnt = ENTRIES - trig_pos.
REQ-023 armed = 1 exactly while state is ARMED (registered).
REQ-024 ARMED: triggered = 1 -> POST, post_cnt := 0; triggered outside ARMED ignored (including the cycle of the FILL->ARMED transition).
REQ-025 Trigger coincident with smpl_en in ARMED: that sample written and counted as pre-trigger, not in post_cnt.
REQ-026 POST: post_cnt counts writes; -> DONE when post_cnt = trig_pos; trig_pos = 0 -> DONE the cycle after entering POST with no post-trigger writes.
REQ-027 DONE: we = 0; capture_done = 1; waddr frozen, pointing to oldest sample.
REQ-028 dump_req accepted only in DONE -> DUMP; rd_cnt := 0; raddr := waddr; capture_done stays 1.
REQ-029 DUMP: each dump_nxt increments raddr (wrap ENTRIES-1 -> 0) and rd_cnt; buffer read latency is 2 cycles: rd_vld pulses exactly 2 cycles after each raddr issue (issue on dump entry and on each dump_nxt until ENTRIES issued).
REQ-030 dump_last = rd_vld for the ENTRIES-th sample; state -> DONE the cycle after that issue; dump_nxt beyond ENTRIES issues ignored.
REQ-031 dump_nxt outside DUMP, dump_req outside DONE, start outside IDLE/DONE: ignored.
REQ-032 abort in any state except IDLE -> IDLE next cycle, priority over all other inputs; we deasserts that cycle; capture_done := 0; in-flight rd_vld pipeline flushed.
REQ-033 we never asserted in IDLE, DONE, DUMP regardless of smpl_en.

Reset
REQ-034 rst_n = 0 at a clock edge: state IDLE; we, armed, capture_done, rd_vld, dump_last = 0; waddr, raddr, all counters = 0; holds from any state, including mid-capture and mid-dump.
REQ-035 First start honoured on the first edge after rst_n returns to 1.

Verification
REQ-036 ENTRIES=384, trig_pos=100, start, smpl_en every cycle -> armed rises after 284 writes; triggered at write 300 -> DONE after 100 more writes; waddr = 400 mod 384 = 16.
REQ-037 trig_pos=0, trigger once armed -> DONE with zero post-trigger writes; trig_pos=500 -> clamped to 383, armed after 1 write.
REQ-038 triggered held high from start -> ignored during FILL; POST entered only first cycle after armed = 1.
REQ-039 Dump after REQ-036 capture, dump_nxt every 3 cycles -> raddr sequence 16..383, 0..15; 384 rd_vld pulses each 2 cycles after issue; dump_last only on final.
REQ-040 abort mid-POST and mid-DUMP -> IDLE next cycle, we = 0, capture_done = 0, no further rd_vld.
REQ-041 rst_n = 0 during ARMED with smpl_en = 1 -> all outputs 0 next edge; start after release restarts from waddr = 0.
